// File: rtl/wb_pkg.sv
// wb_pkg: shared encodings, state type and default exit code for the writeback stage.
package wb_pkg;
  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_LINK = 2'b10;
  localparam logic [1:0] LD_WORD  = 2'b00;
  localparam logic [1:0] LD_HALF  = 2'b01;
  localparam logic [1:0] LD_BYTE  = 2'b10;
  typedef logic state_t;
  localparam state_t RUN  = 1'b0;
  localparam state_t HALT = 1'b1;
  localparam logic [31:0] DEF_EXIT_CODE = 32'd10;
endpackage

// File: rtl/wb_stage_load_ext.sv
// load_ext: little-endian sub-word load extraction with optional zero-extension.
module load_ext
  import wb_pkg::*;
(
  input  logic [31:0] mem,
  input  logic [1:0]  ldsz,
  input  logic        ldu,
  input  logic [1:0]  lo,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b    = mem[{lo, 3'b000} +: 8];
    h    = lo[1] ? mem[31:16] : mem[15:0];
    data = ldsz == LD_BYTE ? {{24{b[7] & ~ldu}}, b} :
           ldsz == LD_HALF ? {{16{h[15] & ~ldu}}, h} : mem;
  end
endmodule

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB register, single-shot register write, retire counter and syscall halt.
// Define WB_SUBWORD_LOAD_EN to enable byte/half load extraction.
module wb_stage
  import wb_pkg::*;
#(
  parameter logic [31:0] EXIT_CODE = DEF_EXIT_CODE
) (
  input  logic        clk,
  input  logic        asy_rst,
  input  logic        in_valid,
  input  logic        stall,
  input  logic        flush,
  input  logic [4:0]  in_rd,
  input  logic        in_we,
  input  logic [1:0]  in_sel,
  input  logic [31:0] in_alu,
  input  logic [31:0] in_mem,
  input  logic [31:0] in_pc,
  input  logic [1:0]  in_ldsz,
  input  logic        in_ldu,
  input  logic [1:0]  in_addr_lo,
  input  logic        in_syscall,
  input  logic [31:0] in_v0,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data,
  output logic        we,
  output logic        fwd_valid,
  output logic [31:0] retired,
  output logic        halt
);
  logic        valid, done, e_we, e_sys;
  logic [4:0]  e_rd;
  logic [1:0]  e_sel;
  logic [31:0] e_alu, e_mem, e_pc, e_v0, ld_data;
  state_t      state;
  logic        act, run;
  assign run = state == RUN;
  assign act = valid & ~done;
  always_ff @(posedge clk or posedge asy_rst) begin
    if (asy_rst) begin
      valid   <= 1'b0;
      done    <= 1'b0;
      e_rd    <= '0;
      e_we    <= 1'b0;
      e_sel   <= '0;
      e_alu   <= '0;
      e_mem   <= '0;
      e_pc    <= '0;
      e_sys   <= 1'b0;
      e_v0    <= '0;
      state   <= RUN;
      retired <= '0;
    end else begin
      if (flush) begin
        valid <= 1'b0;
        done  <= 1'b0;
      end else if (!stall) begin
        valid <= in_valid;
        done  <= 1'b0;
        e_rd  <= in_rd;
        e_we  <= in_we;
        e_sel <= in_sel;
        e_alu <= in_alu;
        e_mem <= in_mem;
        e_pc  <= in_pc;
        e_sys <= in_syscall;
        e_v0  <= in_v0;
      end else if (act) begin
        done <= 1'b1;
      end
      if (act & run) retired <= retired + 32'd1;
      if (act & run & e_sys & (e_v0 == EXIT_CODE)) state <= HALT;
    end
  end
`ifdef WB_SUBWORD_LOAD_EN
  logic [1:0] e_ldsz, e_lo;
  logic       e_ldu;
  always_ff @(posedge clk or posedge asy_rst) begin
    if (asy_rst) begin
      e_ldsz <= '0;
      e_lo   <= '0;
      e_ldu  <= 1'b0;
    end else if (!flush && !stall) begin
      e_ldsz <= in_ldsz;
      e_lo   <= in_addr_lo;
      e_ldu  <= in_ldu;
    end
  end
  load_ext u_load_ext (
    .mem  (e_mem),
    .ldsz (e_ldsz),
    .ldu  (e_ldu),
    .lo   (e_lo),
    .data (ld_data)
  );
`else
  logic unused_ld;
  assign unused_ld = ^{in_ldsz, in_ldu, in_addr_lo};
  assign ld_data   = e_mem;
`endif
  assign we         = act & e_we & (e_rd != 5'd0) & run;
  assign fwd_valid  = we;
  assign write_reg  = valid ? e_rd : 5'd0;
  assign write_data = e_sel == SEL_LINK ? e_pc + 32'd8 : e_sel == SEL_LOAD ? ld_data : e_alu;
  assign halt       = state == HALT;
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: randomized writeback-stage bench against a behavioural entry model.
module tb_wb_stage;
  logic        clk = 1'b0, asy_rst = 1'b1;
  logic        in_valid, stall, flush, in_we, in_ldu, in_syscall;
  logic [4:0]  in_rd;
  logic [1:0]  in_sel, in_ldsz, in_addr_lo;
  logic [31:0] in_alu, in_mem, in_pc, in_v0;
  logic [4:0]  write_reg;
  logic [31:0] write_data, retired;
  logic        we, fwd_valid, halt;
  int errs = 0, checks = 0;
  always #5 clk = ~clk;
  wb_stage dut (
    .clk(clk), .asy_rst(asy_rst), .in_valid(in_valid), .stall(stall), .flush(flush),
    .in_rd(in_rd), .in_we(in_we), .in_sel(in_sel), .in_alu(in_alu), .in_mem(in_mem),
    .in_pc(in_pc), .in_ldsz(in_ldsz), .in_ldu(in_ldu), .in_addr_lo(in_addr_lo),
    .in_syscall(in_syscall), .in_v0(in_v0), .write_reg(write_reg), .write_data(write_data),
    .we(we), .fwd_valid(fwd_valid), .retired(retired), .halt(halt)
  );
  typedef struct {
    logic [4:0]  rd;
    logic        we, ldu, sys;
    logic [1:0]  sel, ldsz, lo;
    logic [31:0] alu, mem, pc, v0;
  } ent_t;
  ent_t        m_e;
  logic        m_valid, m_used, m_halt;
  logic [31:0] m_ret;
`ifdef WB_SUBWORD_LOAD_EN
  localparam logic [31:0] EXP_LBS = 32'hFFFFFF80;
  localparam logic [31:0] EXP_LBU = 32'h00000080;
`else
  localparam logic [31:0] EXP_LBS = 32'h80FF7F01;
  localparam logic [31:0] EXP_LBU = 32'h80FF7F01;
`endif
  function automatic logic [31:0] f_wdata(ent_t e);
    logic [31:0] v;
    if (e.sel == 2'd2) return e.pc + 32'd8;
    if (e.sel != 2'd1) return e.alu;
`ifdef WB_SUBWORD_LOAD_EN
    if (e.ldsz == 2'd2) begin
      v = (e.mem >> (8 * e.lo)) & 32'hFF;
      return (!e.ldu && v > 32'd127) ? v - 32'd256 : v;
    end
    if (e.ldsz == 2'd1) begin
      v = (e.mem >> (16 * (e.lo / 2))) & 32'hFFFF;
      return (!e.ldu && v > 32'd32767) ? v - 32'd65536 : v;
    end
`endif
    return e.mem;
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic model_reset();
    m_valid = 1'b0;
    m_used  = 1'b0;
    m_halt  = 1'b0;
    m_ret   = '0;
    m_e     = '{default: '0};
  endtask
  task automatic model_step();
    logic a;
    a = m_valid && !m_used;
    if (a && !m_halt) begin
      m_ret = m_ret + 32'd1;
      if (m_e.sys && m_e.v0 == 32'd10) m_halt = 1'b1;
    end
    if (flush) begin
      m_valid = 1'b0;
      m_used  = 1'b0;
    end else if (!stall) begin
      m_e.rd = in_rd; m_e.we = in_we; m_e.sel = in_sel; m_e.alu = in_alu;
      m_e.mem = in_mem; m_e.pc = in_pc; m_e.ldsz = in_ldsz; m_e.lo = in_addr_lo;
      m_e.ldu = in_ldu; m_e.sys = in_syscall; m_e.v0 = in_v0;
      m_valid = in_valid;
      m_used  = 1'b0;
    end else if (a) begin
      m_used = 1'b1;
    end
  endtask
  always @(negedge clk) begin : cmp
    logic a, ew;
    a  = m_valid && !m_used;
    ew = a && m_e.we && m_e.rd != 5'd0 && !m_halt;
    chk("we", we, ew);
    chk("fwd_valid", fwd_valid, ew);
    chk("write_reg", write_reg, m_valid ? m_e.rd : 5'd0);
    chk("write_data", write_data, f_wdata(m_e));
    chk("retired", retired, m_ret);
    chk("halt", halt, m_halt);
  end
  task automatic cyc();
    @(posedge clk);
    if (!asy_rst) model_step();
    #3;
  endtask
  task automatic idle();
    in_valid = 0; stall = 0; flush = 0; in_rd = 0; in_we = 0; in_sel = 0;
    in_alu = 0; in_mem = 0; in_pc = 0; in_ldsz = 0; in_ldu = 0; in_addr_lo = 0;
    in_syscall = 0; in_v0 = 0;
  endtask
  task automatic drv(input logic v, input logic [4:0] rd, input logic w, input logic [1:0] sel,
                     input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc);
    idle();
    in_valid = v; in_rd = rd; in_we = w; in_sel = sel; in_alu = alu; in_mem = mem; in_pc = pc;
  endtask
  task automatic do_reset();
    asy_rst = 1'b1;
    model_reset();
    idle();
    #1 asy_rst = 1'b0;
  endtask
  task automatic rnd(input int n, input bit allow_sys);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'($urandom); stall = ($urandom % 4) == 0; flush = ($urandom % 8) == 0;
      in_rd = 5'($urandom); in_we = 1'($urandom); in_sel = 2'($urandom);
      in_alu = $urandom; in_mem = $urandom; in_pc = $urandom;
      in_ldsz = 2'($urandom); in_ldu = 1'($urandom); in_addr_lo = 2'($urandom);
      in_syscall = allow_sys && ($urandom % 10) == 0;
      in_v0 = ($urandom % 3) == 0 ? 32'd10 : $urandom;
      cyc();
    end
  endtask
  initial begin
    int n;
    model_reset();
    idle();
    repeat (2) @(negedge clk);
    chk("rst_we", we, 0);
    chk("rst_write_data", write_data, 0);
    chk("rst_halt", halt, 0);
    #2 asy_rst = 1'b0;
    drv(1, 8, 1, 2'd0, 32'h1234, 0, 0);
    cyc();
    chk("alu_we", we, 1);
    chk("alu_write_reg", write_reg, 8);
    chk("alu_write_data", write_data, 32'h1234);
    idle();
    cyc();
    chk("alu_retired", retired, 1);
    chk("alu_we_once", we, 0);
    drv(1, 3, 1, 2'd1, 0, 32'h80FF7F01, 0);
    in_ldsz = 2'd2; in_addr_lo = 2'd3;
    cyc();
    chk("lb_signed", write_data, EXP_LBS);
    in_ldu = 1'b1;
    cyc();
    chk("lb_unsigned", write_data, EXP_LBU);
    idle();
    cyc();
    drv(1, 5, 1, 2'd0, 32'h55, 0, 0);
    cyc();
    n = int'(we);
    stall = 1'b1;
    repeat (3) begin
      cyc();
      n += int'(we);
    end
    chk("stall_we_count", n, 1);
    chk("stall_retired", retired, 4);
    drv(1, 0, 1, 2'd0, 32'h77, 0, 0);
    cyc();
    chk("rd0_we", we, 0);
    idle();
    cyc();
    drv(1, 6, 1, 2'd0, 32'h66, 0, 0);
    stall = 1'b1; flush = 1'b1;
    cyc();
    chk("flush_we", we, 0);
    chk("flush_write_reg", write_reg, 0);
    idle();
    cyc();
    chk("flush_retired", retired, 5);
    drv(1, 31, 1, 2'd2, 0, 0, 32'hFFFFFFFC);
    cyc();
    chk("link_data", write_data, 32'h4);
    chk("link_we", we, 1);
    rnd(400, 1'b0);
    do_reset();
    drv(1, 2, 0, 2'd0, 0, 0, 0);
    in_syscall = 1'b1; in_v0 = 32'd10;
    cyc();
    chk("pre_halt", halt, 0);
    idle();
    cyc();
    chk("halt_set", halt, 1);
    chk("halt_retired", retired, 1);
    drv(1, 9, 1, 2'd0, 32'h99, 0, 0);
    cyc();
    chk("halt_we", we, 0);
    idle();
    cyc();
    chk("halt_retired_frozen", retired, 1);
    rnd(50, 1'b1);
    do_reset();
    drv(1, 4, 1, 2'd0, 32'h44, 0, 0);
    cyc();
    chk("midwrite_we", we, 1);
    asy_rst = 1'b1;
    model_reset();
    #1;
    chk("midwrite_we_rst", we, 0);
    chk("rst_halt_clear", halt, 0);
    chk("rst_retired_clear", retired, 0);
    idle();
    asy_rst = 1'b0;
    rnd(600, 1'b1);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
